lcd_bus_monitor: RTL and testbench

Receiving end of the HD44780-style character-LCD write bus (E/RS/RW/DATA) that the text-LCD driver produces. It samples the bus on the system clock, decodes each E-falling-edge transfer as an instruction or a data write, and maintains a mirror of the 2×16 display RAM together with the controller mode flags. It sits beside the LCD driver, both as an on-chip mirror (debug, VGA/UART echo) and as the bench-side responder model that checks the driver.

---
 rtl/lcd_pkg.sv | 83 ++++++++
 rtl/lcd_bus_monitor_if.sv | 19 +
 rtl/lcd_bus_sync.sv | 65 ++++++
 rtl/lcd_bus_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_lcd_bus_monitor.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style bus monitor: instruction opcode
// masks, display RAM geometry, the monitor FSM state type, the decoded
// instruction class, and helpers for DDRAM address stepping and for mapping
// a DDRAM address onto the 32-cell mirror.
// -----------------------------------------------------------------------------
package lcd_pkg;

    // Blank character written by reset and by clear-display
    localparam logic [7:0] BLANK = 8'h20;

    // DDRAM geometry for a 2-line display (40 positions per line)
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_END  = 7'h27;
    localparam logic [6:0] LINE1_END  = 7'h67;

    // Mirror holds 2 lines x 16 visible columns
    localparam int NUM_CELLS = 32;

    // Instruction opcode masks; the highest set bit selects the instruction
    localparam logic [7:0] OP_DDRAM = 8'h80;
    localparam logic [7:0] OP_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNC  = 8'h20;
    localparam logic [7:0] OP_SHIFT = 8'h10;
    localparam logic [7:0] OP_DISP  = 8'h08;
    localparam logic [7:0] OP_ENTRY = 8'h04;
    localparam logic [7:0] OP_HOME  = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        INS_NOP   = 3'd0,  // CGRAM address, cursor/display shift, 0x00
        INS_DDRAM = 3'd1,
        INS_FUNC  = 3'd2,
        INS_DISP  = 3'd3,
        INS_ENTRY = 3'd4,
        INS_HOME  = 3'd5,
        INS_CLEAR = 3'd6
    } ins_e;

    function automatic ins_e decode_ins(input logic [7:0] b);
        if      ((b & OP_DDRAM) != 8'h00) return INS_DDRAM;
        else if ((b & OP_CGRAM) != 8'h00) return INS_NOP;
        else if ((b & OP_FUNC)  != 8'h00) return INS_FUNC;
        else if ((b & OP_SHIFT) != 8'h00) return INS_NOP;
        else if ((b & OP_DISP)  != 8'h00) return INS_DISP;
        else if ((b & OP_ENTRY) != 8'h00) return INS_ENTRY;
        else if ((b & OP_HOME)  != 8'h00) return INS_HOME;
        else if ((b & OP_CLEAR) != 8'h00) return INS_CLEAR;
        else                              return INS_NOP;
    endfunction

    // Visible window: 0x00-0x0F and 0x40-0x4F, i.e. bits [5:4] clear
    function automatic logic in_window(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    // Mirror cell index: {line, column}
    function automatic logic [4:0] cell_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // Address counter step; wraps between the two 40-position lines
    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == LINE0_END) return LINE1_BASE;
            if (a == LINE1_END) return LINE0_BASE;
            return a + 7'd1;
        end else begin
            if (a == LINE0_BASE) return LINE1_END;
            if (a == LINE1_BASE) return LINE0_END;
            return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_bus_monitor_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_monitor_if
// The character-LCD write bus as seen on the module pins.
//   lcd_e    : enable; a transfer completes on its falling edge
//   lcd_rs   : 0 = instruction, 1 = data
//   lcd_rw   : 0 = write, 1 = read
//   lcd_data : 8-bit bus data
// master : the LCD driver side (drives every line)
// slave  : the monitor side (observes every line)
// -----------------------------------------------------------------------------
interface lcd_bus_monitor_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output lcd_e, output lcd_rs, output lcd_rw, output lcd_data);
    modport slave  (input  lcd_e, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd_bus_sync.sv
// -----------------------------------------------------------------------------
// lcd_bus_sync
// Brings the asynchronous LCD bus into the clk domain and detects E falling
// edges. Every bus line runs through an identical SYNC_STAGES-deep chain plus
// one extra "previous" stage, so RS/RW/DATA stay aligned with E. On a fall,
// the previous-stage values (sampled while E was still high) are captured.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   lcd_e_i/rs_i/rw_i/data_i : raw bus lines
//   fall_o                : one-cycle strobe per E falling edge
//   rs_o, rw_o, data_o    : bus contents of the transfer, held until the next
// -----------------------------------------------------------------------------
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_e_i,
    input  logic       lcd_rs_i,
    input  logic       lcd_rw_i,
    input  logic [7:0] lcd_data_i,
    output logic       fall_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [7:0] data_o
);

    // Index 0 is the first synchronizer flop, SYNC_STAGES-1 the last,
    // SYNC_STAGES the previous-value stage used for edge detection.
    logic [SYNC_STAGES:0] e_q;
    logic [9:0]           bus_q [SYNC_STAGES+1];
    logic                 fall_q;
    logic [9:0]           cap_q;
    logic                 fall_w;

    assign fall_w = e_q[SYNC_STAGES] & ~e_q[SYNC_STAGES-1];

    // E is reset low so a bus already held high at release is not a fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q    <= '0;
            fall_q <= 1'b0;
            cap_q  <= '0;
            for (int i = 0; i <= SYNC_STAGES; i++) begin
                bus_q[i] <= '0;
            end
        end else begin
            e_q      <= {e_q[SYNC_STAGES-1:0], lcd_e_i};
            bus_q[0] <= {lcd_rs_i, lcd_rw_i, lcd_data_i};
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                bus_q[i] <= bus_q[i-1];
            end
            fall_q <= fall_w;
            if (fall_w) begin
                cap_q <= bus_q[SYNC_STAGES];
            end
        end
    end

    assign fall_o = fall_q;
    assign rs_o   = cap_q[9];
    assign rw_o   = cap_q[8];
    assign data_o = cap_q[7:0];

endmodule

// File: rtl/lcd_bus_monitor.sv
// -----------------------------------------------------------------------------
// lcd_bus_monitor
// Receiving end of the HD44780-style write bus. Decodes every E-falling-edge
// write transfer as an instruction or a data write, keeps a mirror of the
// 2x16 visible DDRAM and the controller mode flags.
// Ports:
//   clk, resetn          : system clock, asynchronous active-low reset
//   bus                  : LCD bus (E/RS/RW/DATA), asynchronous to clk
//   rd_addr / rd_data    : combinational mirror read, {line, column}
//   addr_cnt             : DDRAM address counter
//   busy                 : clear-display in progress
//   disp_on..func_f      : controller mode flags
//   cmd_valid / cmd_code : instruction pulse and last instruction byte
//   data_wr              : data-write pulse (also for dropped bytes)
//   proto_err            : pulse for a write transfer received while busy
// -----------------------------------------------------------------------------
module lcd_bus_monitor
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int CLEAR_CYCLES = 32
) (
    input  logic              clk,
    input  logic              resetn,
    lcd_bus_monitor_if.slave  bus,
    input  logic [4:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [6:0]        addr_cnt,
    output logic              busy,
    output logic              disp_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              entry_id,
    output logic              entry_sh,
    output logic              func_dl,
    output logic              func_n,
    output logic              func_f,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic              data_wr,
    output logic              proto_err
);

    localparam int CW = $clog2(CLEAR_CYCLES) + 1;

    // Synchronized transfer
    logic       x_fall;
    logic       x_rs;
    logic       x_rw;
    logic [7:0] x_data;

    lcd_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_e_i    (bus.lcd_e),
        .lcd_rs_i   (bus.lcd_rs),
        .lcd_rw_i   (bus.lcd_rw),
        .lcd_data_i (bus.lcd_data),
        .fall_o     (x_fall),
        .rs_o       (x_rs),
        .rw_o       (x_rw),
        .data_o     (x_data)
    );

    state_e         state_q, state_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     mem_q [NUM_CELLS];
    logic [7:0]     mem_d [NUM_CELLS];
    logic [7:0]     cmd_code_q, cmd_code_d;
    logic           disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic           id_q, id_d, sh_q, sh_d;
    logic           dl_q, dl_d, n_q, n_d, f_q, f_d;
    logic           ex_cmd_q, ex_cmd_d;     // transfer in EXEC is an instruction
    logic           ex_clr_q, ex_clr_d;     // ... and that instruction is clear
    logic [CW-1:0]  clr_cnt_q, clr_cnt_d;
    logic           perr_q, perr_d;

    logic           wr_xfer;
    logic           accept;
    ins_e           ins;

    assign wr_xfer = x_fall & ~x_rw;
    assign accept  = wr_xfer && (state_q == ST_IDLE);
    assign ins     = decode_ins(x_data);

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_EXEC;
            ST_EXEC:  state_d = ex_clr_q ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. The EXEC cycle of a clear is the first busy cycle, so
    // busy spans EXEC plus CLEAR_CYCLES-1 cycles of CLEAR.
    always_comb begin
        busy      = 1'b0;
        cmd_valid = 1'b0;
        data_wr   = 1'b0;
        unique case (state_q)
            ST_EXEC: begin
                busy      = ex_clr_q;
                cmd_valid = ex_cmd_q;
                data_wr   = ~ex_cmd_q;
            end
            ST_CLEAR: busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state: transfer effects land on the edge that enters EXEC
    always_comb begin
        addr_d     = addr_q;
        mem_d      = mem_q;
        cmd_code_d = cmd_code_q;
        disp_d     = disp_q;
        cur_d      = cur_q;
        blink_d    = blink_q;
        id_d       = id_q;
        sh_d       = sh_q;
        dl_d       = dl_q;
        n_d        = n_q;
        f_d        = f_q;
        ex_cmd_d   = ex_cmd_q;
        ex_clr_d   = ex_clr_q;
        clr_cnt_d  = clr_cnt_q;
        perr_d     = wr_xfer && busy;

        if (accept) begin
            ex_cmd_d  = ~x_rs;
            ex_clr_d  = ~x_rs && (ins == INS_CLEAR);
            clr_cnt_d = '0;
            if (x_rs) begin
                // Bytes outside the visible window still advance the counter
                if (in_window(addr_q)) begin
                    mem_d[cell_idx(addr_q)] = x_data;
                end
                addr_d = step_addr(addr_q, id_q);
            end else begin
                cmd_code_d = x_data;
                unique case (ins)
                    INS_DDRAM: addr_d = x_data[6:0];
                    INS_FUNC: begin
                        dl_d = x_data[4];
                        n_d  = x_data[3];
                        f_d  = x_data[2];
                    end
                    INS_DISP: begin
                        disp_d  = x_data[2];
                        cur_d   = x_data[1];
                        blink_d = x_data[0];
                    end
                    INS_ENTRY: begin
                        id_d = x_data[1];
                        sh_d = x_data[0];
                    end
                    INS_HOME: addr_d = LINE0_BASE;
                    INS_CLEAR: begin
                        addr_d = LINE0_BASE;
                        id_d   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (busy) begin
            // One cell per busy cycle; counts past the mirror only burn time
            if (clr_cnt_q < CW'(NUM_CELLS)) begin
                mem_d[clr_cnt_q[4:0]] = BLANK;
            end
            clr_cnt_d = clr_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= LINE0_BASE;
            cmd_code_q <= 8'h00;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            id_q       <= 1'b1;
            sh_q       <= 1'b0;
            dl_q       <= 1'b0;
            n_q        <= 1'b0;
            f_q        <= 1'b0;
            ex_cmd_q   <= 1'b0;
            ex_clr_q   <= 1'b0;
            clr_cnt_q  <= '0;
            perr_q     <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_q[i] <= BLANK;
            end
        end else begin
            addr_q     <= addr_d;
            cmd_code_q <= cmd_code_d;
            disp_q     <= disp_d;
            cur_q      <= cur_d;
            blink_q    <= blink_d;
            id_q       <= id_d;
            sh_q       <= sh_d;
            dl_q       <= dl_d;
            n_q        <= n_d;
            f_q        <= f_d;
            ex_cmd_q   <= ex_cmd_d;
            ex_clr_q   <= ex_clr_d;
            clr_cnt_q  <= clr_cnt_d;
            perr_q     <= perr_d;
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data   = mem_q[rd_addr];
    assign addr_cnt  = addr_q;
    assign cmd_code  = cmd_code_q;
    assign disp_on   = disp_q;
    assign cursor_on = cur_q;
    assign blink_on  = blink_q;
    assign entry_id  = id_q;
    assign entry_sh  = sh_q;
    assign func_dl   = dl_q;
    assign func_n    = n_q;
    assign func_f    = f_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_monitor
// Directed bench for lcd_bus_monitor: drives bus transfers through the
// interface and compares flags, counters, pulse counts and mirror cells
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_lcd_bus_monitor;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    lcd_bus_monitor_if bus ();

    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] addr_cnt;
    logic       busy, disp_on, cursor_on, blink_on, entry_id, entry_sh;
    logic       func_dl, func_n, func_f, cmd_valid, data_wr, proto_err;
    logic [7:0] cmd_code;

    lcd_bus_monitor #(
        .SYNC_STAGES  (2),
        .CLEAR_CYCLES (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .addr_cnt  (addr_cnt),
        .busy      (busy),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .entry_id  (entry_id),
        .entry_sh  (entry_sh),
        .func_dl   (func_dl),
        .func_n    (func_n),
        .func_f    (func_f),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .data_wr   (data_wr),
        .proto_err (proto_err)
    );

    // Pulse and busy-cycle counters
    int n_cmd = 0, n_data = 0, n_perr = 0, n_busy = 0;
    always @(posedge clk) begin
        if (cmd_valid === 1'b1) n_cmd  <= n_cmd + 1;
        if (data_wr   === 1'b1) n_data <= n_data + 1;
        if (proto_err === 1'b1) n_perr <= n_perr + 1;
        if (busy      === 1'b1) n_busy <= n_busy + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cell(input int idx, input logic [7:0] exp);
        rd_addr = idx[4:0];
        #1;
        check($sformatf("cell%0d", idx), {24'h0, rd_data}, {24'h0, exp});
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs   = rs;
        bus.lcd_rw   = rw;
        bus.lcd_data = d;
        bus.lcd_e    = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    int b_cmd, b_data, b_perr, b_busy;
    logic [7:0] word [5];

    initial begin
        word = '{8'h43, 8'h4C, 8'h4F, 8'h43, 8'h4B};
        resetn       = 1'b0;
        rd_addr      = 5'd0;
        bus.lcd_e    = 1'b0;
        bus.lcd_rs   = 1'b1;
        bus.lcd_rw   = 1'b1;
        bus.lcd_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_addr",  {25'h0, addr_cnt}, 32'h00);
        check("rst_id",    {31'h0, entry_id}, 32'h1);
        check("rst_busy",  {31'h0, busy},     32'h0);
        check("rst_disp",  {31'h0, disp_on},  32'h0);
        check("rst_dl",    {31'h0, func_dl},  32'h0);
        check("rst_code",  {24'h0, cmd_code}, 32'h00);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Function set with detect-latency check, then display and entry mode
        b_cmd = n_cmd;
        @(negedge clk);
        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h38; bus.lcd_e = 1'b1;
        repeat (3) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_early", {31'h0, cmd_valid}, 32'h0);
        @(negedge clk);
        check("lat_pulse", {31'h0, cmd_valid}, 32'h1);
        check("lat_dl",    {31'h0, func_dl},   32'h1);
        repeat (3) @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0C);
        xfer(1'b0, 1'b0, 8'h06);
        check("init_dl",    {31'h0, func_dl},   32'h1);
        check("init_n",     {31'h0, func_n},    32'h1);
        check("init_f",     {31'h0, func_f},    32'h0);
        check("init_disp",  {31'h0, disp_on},   32'h1);
        check("init_cur",   {31'h0, cursor_on}, 32'h0);
        check("init_blink", {31'h0, blink_on},  32'h0);
        check("init_id",    {31'h0, entry_id},  32'h1);
        check("init_sh",    {31'h0, entry_sh},  32'h0);
        check("init_ncmd",  n_cmd - b_cmd,      32'd3);
        check("init_code",  {24'h0, cmd_code},  32'h06);

        // "CLOCK" on line 0
        b_data = n_data;
        xfer(1'b0, 1'b0, 8'h80);
        for (int i = 0; i < 5; i++) xfer(1'b1, 1'b0, word[i]);
        for (int i = 0; i < 5; i++) check_cell(i, word[i]);
        check("clock_addr",  {25'h0, addr_cnt}, 32'h05);
        check("clock_ndata", n_data - b_data,   32'd5);

        // Line 1 fill; the 17th byte lands at 0x50 and is dropped
        b_data = n_data;
        xfer(1'b0, 1'b0, 8'hC0);
        for (int i = 0; i < 17; i++) xfer(1'b1, 1'b0, 8'h30 + 8'(i));
        for (int i = 16; i < 32; i++) check_cell(i, 8'h30 + 8'(i - 16));
        check("l1_addr",  {25'h0, addr_cnt}, 32'h51);
        check("l1_ndata", n_data - b_data,   32'd17);
        check_cell(0, 8'h43);

        // Clear display with a write arriving mid-clear
        b_busy = n_busy; b_perr = n_perr; b_data = n_data;
        xfer(1'b0, 1'b0, 8'h01);
        check("clr_busy_on", {31'h0, busy}, 32'h1);
        xfer(1'b1, 1'b0, 8'h99);
        repeat (40) @(negedge clk);
        check("clr_busy_off", {31'h0, busy},     32'h0);
        check("clr_ncycles",  n_busy - b_busy,   32'd32);
        check("clr_nperr",    n_perr - b_perr,   32'd1);
        check("clr_ndata",    n_data - b_data,   32'd0);
        check("clr_addr",     {25'h0, addr_cnt}, 32'h00);
        check("clr_id",       {31'h0, entry_id}, 32'h1);
        check("clr_code",     {24'h0, cmd_code}, 32'h01);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);

        // Reset during a second clear
        xfer(1'b0, 1'b0, 8'hC4);
        xfer(1'b1, 1'b0, 8'h5A);
        xfer(1'b0, 1'b0, 8'h0F);
        check_cell(20, 8'h5A);
        xfer(1'b0, 1'b0, 8'h01);
        check("clr2_busy", {31'h0, busy}, 32'h1);
        resetn = 1'b0;
        #1;
        check("mrst_busy", {31'h0, busy},     32'h0);
        check("mrst_addr", {25'h0, addr_cnt}, 32'h00);
        check("mrst_disp", {31'h0, disp_on},  32'h0);
        check("mrst_id",   {31'h0, entry_id}, 32'h1);
        check("mrst_code", {24'h0, cmd_code}, 32'h00);
        check_cell(20, 8'h20);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Decrement mode and wraps, RW=1 transfers ignored
        xfer(1'b0, 1'b0, 8'h04);
        check("dec_id", {31'h0, entry_id}, 32'h0);
        xfer(1'b0, 1'b0, 8'h80);
        xfer(1'b1, 1'b0, 8'h41);
        check_cell(0, 8'h41);
        check("dec_wrap0", {25'h0, addr_cnt}, 32'h67);
        b_cmd = n_cmd; b_data = n_data;
        xfer(1'b1, 1'b1, 8'h77);
        xfer(1'b0, 1'b1, 8'h01);
        check("rd_ncmd",  n_cmd - b_cmd,     32'd0);
        check("rd_ndata", n_data - b_data,   32'd0);
        check("rd_busy",  {31'h0, busy},     32'h0);
        check("rd_addr",  {25'h0, addr_cnt}, 32'h67);
        xfer(1'b0, 1'b0, 8'hC0);
        xfer(1'b1, 1'b0, 8'h42);
        check_cell(16, 8'h42);
        check("dec_wrap1", {25'h0, addr_cnt}, 32'h27);

        // Increment wraps through the invisible ends of each line
        xfer(1'b0, 1'b0, 8'h06);
        xfer(1'b0, 1'b0, 8'hA7);
        xfer(1'b1, 1'b0, 8'h55);
        check("inc_wrap0", {25'h0, addr_cnt}, 32'h40);
        check_cell(16, 8'h42);
        xfer(1'b0, 1'b0, 8'hE7);
        check("inc_code", {24'h0, cmd_code}, 32'hE7);
        xfer(1'b1, 1'b0, 8'h56);
        check("inc_wrap1", {25'h0, addr_cnt}, 32'h00);
        check_cell(0, 8'h41);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
